// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle fetch/decode/execute sequencer.
//
// Walks IDLE -> FETCH -> DECODE -> EXEC for each instruction. Owns the
// program counter (addr_inst into the instruction regfile) and the latched
// instruction register. Everything other than state/pc/ir/done is decoded
// combinationally from the current state and ir.
//
// Ports
//   clock, reset      rising-edge clock, async active-high reset
//   start             launch execution from pc=0 (looked at only in IDLE)
//   ins               instruction word read at addr_inst
//   rs0_data          dreg read port 0 data, used as the jump target
//   mem_ack           data memory completes the pending request
//   addr_inst         program counter (driven during FETCH)
//   addr_rs0/rs1/rd   dreg read/write addresses
//   rd_we, en_mv      dreg write / move strobes
//   wb_sel            dreg write source: 0 ALU, 1 memory
//   alu_op            ALU opcode
//   mem_req, mem_we   memory request, 1 = store
//   mem_addr          memory address
//   busy              not IDLE
//   done              one-cycle pulse after the last pc wraps to 0
module ctrl_seq #(
  parameter int BIT = 16,
  parameter int SZB = 4,
  parameter int SZI = 4,
  parameter int SZM = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [BIT-1:0] ins,
  input  logic [BIT-1:0] rs0_data,
  input  logic           mem_ack,
  output logic [SZI-1:0] addr_inst,
  output logic [SZB-1:0] addr_rs0,
  output logic [SZB-1:0] addr_rs1,
  output logic [SZB-1:0] addr_rd,
  output logic           rd_we,
  output logic           en_mv,
  output logic           wb_sel,
  output logic [3:0]     alu_op,
  output logic           mem_req,
  output logic           mem_we,
  output logic [SZM-1:0] mem_addr,
  output logic           busy,
  output logic           done
);

  // Opcode map. Everything up to OP_DIV is an ALU operation.
  localparam logic [3:0] OP_INV   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_XNOR  = 4'd4;
  localparam logic [3:0] OP_COM   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_MOVE  = 4'd12;
  localparam logic [3:0] OP_JUMP  = 4'd13;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  localparam logic [SZI-1:0] PC_ONE = SZI'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC} state_t;

  state_t         r_state, w_state_nxt;
  logic [SZI-1:0] r_pc, w_pc_nxt;
  logic [BIT-1:0] r_ir, w_ir_nxt;
  logic           r_done, w_done_nxt;

  logic [3:0]     w_op;
  logic [SZB-1:0] w_a, w_b, w_c;
  logic           w_is_alu;
  logic           w_step;     // current instruction retires on this edge
  logic           w_unused_rs0;

  assign w_op     = r_ir[15:12];
  assign w_a      = r_ir[11:8];
  assign w_b      = r_ir[7:4];
  assign w_c      = r_ir[3:0];
  assign w_is_alu = (w_op <= OP_DIV);

  // Only the low SZI bits of the jump source form the target.
  assign w_unused_rs0 = ^rs0_data[BIT-1:SZI];

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_done_nxt  = 1'b0;
    w_step      = 1'b0;
    addr_inst   = '0;
    addr_rs0    = '0;
    addr_rs1    = '0;
    addr_rd     = '0;
    rd_we       = 1'b0;
    en_mv       = 1'b0;
    wb_sel      = 1'b0;
    alu_op      = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;

    // Register-file addresses are set up in DECODE and held through EXEC,
    // so they stay stable for the whole of a memory wait.
    if (r_state == S_DECODE || r_state == S_EXEC) begin
      if (w_is_alu) begin
        addr_rd  = w_a;
        addr_rs0 = w_b;
        addr_rs1 = w_c;
      end else begin
        case (w_op)
          OP_MOVE:  begin addr_rd = w_a; addr_rs0 = w_b; end
          OP_JUMP:  addr_rs0 = w_a;
          OP_LOAD:  addr_rd  = w_a;
          OP_STORE: addr_rs0 = w_c;
          default:  ;
        endcase
      end
    end

    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        addr_inst   = r_pc;
        w_ir_nxt    = ins;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_is_alu) begin
          alu_op = w_op;
          rd_we  = 1'b1;
          w_step = 1'b1;
        end else begin
          case (w_op)
            OP_MOVE: begin
              en_mv  = 1'b1;
              w_step = 1'b1;
            end
            OP_JUMP: w_step = 1'b1;
            OP_LOAD: begin
              mem_req  = 1'b1;
              mem_addr = {w_b, w_c};
              wb_sel   = 1'b1;
              rd_we    = mem_ack;  // write back only as the data arrives
              w_step   = mem_ack;
            end
            OP_STORE: begin
              mem_req  = 1'b1;
              mem_we   = 1'b1;
              mem_addr = {w_a, w_b};
              w_step   = mem_ack;
            end
            default: w_step = 1'b1;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_step) begin
      if (w_op == OP_JUMP) begin
        w_pc_nxt    = rs0_data[SZI-1:0];
        w_state_nxt = S_FETCH;
      end else if (&r_pc) begin
        // Last slot retired: wrap and report completion.
        w_pc_nxt    = '0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_pc_nxt    = r_pc + PC_ONE;
        w_state_nxt = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Testbench for ctrl_seq: directed scenarios plus a randomized program run,
// each cycle compared against an instruction-level reference model.
module tb_ctrl_seq;

  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_MOVE  = 4'd12;
  localparam logic [3:0] OP_JUMP  = 4'd13;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_DEC   = 2;
  localparam int P_EXEC  = 3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] ai;
    logic [3:0] rs0;
    logic [3:0] rs1;
    logic [3:0] rd;
    logic       rd_we;
    logic       en_mv;
    logic       wb_sel;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
  } outs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] ins, rs0_data;
  logic [3:0]  addr_inst, addr_rs0, addr_rs1, addr_rd, alu_op;
  logic        rd_we, en_mv, wb_sel, mem_req, mem_we, busy, done;
  logic [7:0]  mem_addr;

  logic [15:0] prog  [16];
  logic [15:0] dregs [16];

  int    vectors = 0;
  int    errors  = 0;
  outs_t obs, o, e;

  // Instruction memory and data regfile read ports are combinational.
  assign ins      = prog[addr_inst];
  assign rs0_data = dregs[addr_rs0];
  assign obs = {busy, done, addr_inst, addr_rs0, addr_rs1, addr_rd, rd_we,
                en_mv, wb_sel, alu_op, mem_req, mem_we, mem_addr};

  always #5 clock = ~clock;

  ctrl_seq dut (
    .clock(clock), .reset(reset), .start(start), .ins(ins),
    .rs0_data(rs0_data), .mem_ack(mem_ack), .addr_inst(addr_inst),
    .addr_rs0(addr_rs0), .addr_rs1(addr_rs1), .addr_rd(addr_rd),
    .rd_we(rd_we), .en_mv(en_mv), .wb_sel(wb_sel), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .busy(busy), .done(done)
  );

  // Reference: expected outputs for an instruction in a given phase.
  function automatic outs_t exp_f(input int ph, input logic [3:0] pc,
                                  input logic [15:0] ir, input logic ack,
                                  input logic dn);
    outs_t r;
    logic [3:0] op, a, b, c;
    r = '0;
    {op, a, b, c} = ir;
    if (ph == P_IDLE) begin
      r.done = dn;
      return r;
    end
    r.busy = 1'b1;
    if (ph == P_FETCH) begin
      r.ai = pc;
      return r;
    end
    if (op <= OP_DIV) begin
      r.rd = a; r.rs0 = b; r.rs1 = c;
    end else if (op == OP_MOVE) begin
      r.rd = a; r.rs0 = b;
    end else if (op == OP_JUMP) r.rs0 = a;
    else if (op == OP_LOAD)     r.rd  = a;
    else                        r.rs0 = c;
    if (ph == P_EXEC) begin
      if (op <= OP_DIV) begin
        r.alu_op = op; r.rd_we = 1'b1;
      end else if (op == OP_MOVE) r.en_mv = 1'b1;
      else if (op == OP_LOAD) begin
        r.mem_req = 1'b1; r.mem_addr = {b, c}; r.wb_sel = 1'b1; r.rd_we = ack;
      end else if (op == OP_STORE) begin
        r.mem_req = 1'b1; r.mem_we = 1'b1; r.mem_addr = {a, b};
      end
    end
    return r;
  endfunction

  // One clock: drive inputs just after the edge, sample mid-cycle.
  task automatic adv(input logic st, input logic ack);
    @(posedge clock);
    #1;
    start   = st;
    mem_ack = ack;
    #5;
    o = obs;
  endtask

  task automatic pulse_reset;
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2 o = obs;
    e = '0;
    vectors++; if (o !== e) begin errors++; $display("FAIL reset_async: got %h want %h", o, e); end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int s = 0; s < 10; s++) begin
      adv(1'b0, 1'($urandom));
      e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, 1'b0);
      vectors++; if (o !== e) begin errors++; $display("FAIL reset_idle s%0d: got %h want %h", s, o, e); end
    end
  endtask

  // Starts in IDLE; leaves DUT sampled in FETCH of pc=1.
  task automatic test_alu;
    logic [15:0] ir;
    ir = {OP_ADD, 4'd11, 4'd3, 4'd2};
    prog[0] = ir;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin adv(1'b1, 1'b0); e = exp_f(P_IDLE,  4'd0, ir, 1'b0, 1'b0); end
        1: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd0, ir, 1'b0, 1'b0); end
        2: begin adv(1'b1, 1'b0); e = exp_f(P_DEC,   4'd0, ir, 1'b0, 1'b0); end
        3: begin adv(1'b0, 1'b1); e = exp_f(P_EXEC,  4'd0, ir, 1'b1, 1'b0); end
        default: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd1, ir, 1'b0, 1'b0); end
      endcase
      vectors++; if (o !== e) begin errors++; $display("FAIL alu s%0d: got %h want %h", s, o, e); end
    end
  endtask

  task automatic test_move;
    logic [15:0] ir;
    ir = {OP_MOVE, 4'd0, 4'd2, 4'd0};
    prog[1] = ir;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin adv(1'b0, 1'b0); e = exp_f(P_DEC,  4'd1, ir, 1'b0, 1'b0); end
        1: begin adv(1'b0, 1'b1); e = exp_f(P_EXEC, 4'd1, ir, 1'b1, 1'b0); end
        default: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd2, ir, 1'b0, 1'b0); end
      endcase
      vectors++; if (o !== e) begin errors++; $display("FAIL move s%0d: got %h want %h", s, o, e); end
    end
  endtask

  task automatic test_jump;
    logic [15:0] ir;
    ir = {OP_JUMP, 4'd2, 8'd0};
    prog[2]  = ir;
    dregs[2] = 16'hA5F7;  // only the low nibble forms the target
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin adv(1'b0, 1'b0); e = exp_f(P_DEC,  4'd2, ir, 1'b0, 1'b0); end
        1: begin adv(1'b0, 1'b0); e = exp_f(P_EXEC, 4'd2, ir, 1'b0, 1'b0); end
        default: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd7, ir, 1'b0, 1'b0); end
      endcase
      vectors++; if (o !== e) begin errors++; $display("FAIL jump s%0d: got %h want %h", s, o, e); end
    end
  endtask

  task automatic test_load_store;
    logic [15:0] ld, st;
    ld = {OP_LOAD, 4'd5, 8'h3C};
    st = {OP_STORE, 8'h01, 4'd1};
    prog[7] = ld;
    prog[8] = st;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin adv(1'b0, 1'b0); e = exp_f(P_DEC, 4'd7, ld, 1'b0, 1'b0); end
        1, 2, 3: begin adv(1'b1, 1'b0); e = exp_f(P_EXEC, 4'd7, ld, 1'b0, 1'b0); end
        4: begin adv(1'b0, 1'b1); e = exp_f(P_EXEC,  4'd7, ld, 1'b1, 1'b0); end
        5: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd8, ld, 1'b0, 1'b0); end
        6: begin adv(1'b0, 1'b0); e = exp_f(P_DEC,   4'd8, st, 1'b0, 1'b0); end
        7: begin adv(1'b0, 1'b1); e = exp_f(P_EXEC,  4'd8, st, 1'b1, 1'b0); end
        default: begin adv(1'b0, 1'b0); e = exp_f(P_FETCH, 4'd9, st, 1'b0, 1'b0); end
      endcase
      vectors++; if (o !== e) begin errors++; $display("FAIL ldst s%0d: got %h want %h", s, o, e); end
    end
  endtask

  task automatic test_wrap;
    int dones;
    dones = 0;
    for (int i = 0; i < 16; i++)
      prog[i] = {4'($urandom_range(1, 11)), 12'($urandom)};
    pulse_reset();
    adv(1'b1, 1'b0);
    for (int pc = 0; pc < 16; pc++) begin
      for (int ph = P_FETCH; ph <= P_EXEC; ph++) begin
        adv(1'b0, 1'b0);
        if (o.done) dones++;
        e = exp_f(ph, 4'(pc), prog[pc], 1'b0, 1'b0);
        vectors++; if (o !== e) begin errors++; $display("FAIL wrap pc%0d ph%0d: got %h want %h", pc, ph, o, e); end
      end
    end
    for (int s = 0; s < 3; s++) begin
      adv(1'b0, 1'b0);
      if (o.done) dones++;
      e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, s == 0);
      vectors++; if (o !== e) begin errors++; $display("FAIL wrap_idle s%0d: got %h want %h", s, o, e); end
    end
    vectors++; if (dones !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid_load;
    logic [15:0] ir;
    ir = {OP_LOAD, 4'd9, 8'hA7};
    prog[0] = ir;
    adv(1'b1, 1'b0);
    adv(1'b0, 1'b0);
    e = exp_f(P_FETCH, 4'd0, ir, 1'b0, 1'b0);
    vectors++; if (o !== e) begin errors++; $display("FAIL rml_fetch: got %h want %h", o, e); end
    adv(1'b0, 1'b0);
    adv(1'b0, 1'b0);
    e = exp_f(P_EXEC, 4'd0, ir, 1'b0, 1'b0);
    vectors++; if (o !== e) begin errors++; $display("FAIL rml_wait: got %h want %h", o, e); end
    #1 reset = 1'b1;
    #1 o = obs;
    e = '0;
    vectors++; if (o !== e) begin errors++; $display("FAIL rml_async: got %h want %h", o, e); end
    @(posedge clock);
    #1 reset = 1'b0;
    adv(1'b0, 1'b1);
    e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, 1'b0);
    vectors++; if (o !== e) begin errors++; $display("FAIL rml_idle: got %h want %h", o, e); end
    adv(1'b1, 1'b0);
    adv(1'b0, 1'b0);
    e = exp_f(P_FETCH, 4'd0, ir, 1'b0, 1'b0);
    vectors++; if (o !== e) begin errors++; $display("FAIL rml_restart: got %h want %h", o, e); end
  endtask

  // Random program; model tracks pc at instruction level.
  task automatic test_random;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        ack;
    int          w;
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      prog[i]  = {4'($urandom_range(1, 15)), 12'($urandom)};
      dregs[i] = 16'($urandom);
    end
    pc = 4'd0;
    adv(1'b1, 1'b0);
    e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, 1'b0);
    vectors++; if (o !== e) begin errors++; $display("FAIL rand_idle: got %h want %h", o, e); end
    for (int n = 0; n < 150; n++) begin
      ir = prog[pc];
      adv(1'($urandom), 1'($urandom));
      e = exp_f(P_FETCH, pc, ir, 1'b0, 1'b0);
      vectors++; if (o !== e) begin errors++; $display("FAIL rand_fetch n%0d: got %h want %h", n, o, e); end
      adv(1'($urandom), 1'($urandom));
      e = exp_f(P_DEC, pc, ir, 1'b0, 1'b0);
      vectors++; if (o !== e) begin errors++; $display("FAIL rand_dec n%0d: got %h want %h", n, o, e); end
      w = (ir[15:12] == OP_LOAD || ir[15:12] == OP_STORE) ? $urandom_range(0, 3) : 0;
      for (int k = 0; k <= w; k++) begin
        ack = (ir[15:12] == OP_LOAD || ir[15:12] == OP_STORE) ? (k == w) : 1'($urandom);
        adv(1'($urandom), ack);
        e = exp_f(P_EXEC, pc, ir, ack, 1'b0);
        vectors++; if (o !== e) begin errors++; $display("FAIL rand_exec n%0d k%0d: got %h want %h", n, k, o, e); end
      end
      if (ir[15:12] == OP_JUMP) pc = dregs[ir[11:8]][3:0];
      else if (pc == 4'hF) begin
        pc = 4'd0;
        adv(1'b0, 1'b0);
        e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, 1'b1);
        vectors++; if (o !== e) begin errors++; $display("FAIL rand_done n%0d: got %h want %h", n, o, e); end
        adv(1'b1, 1'b0);
        e = exp_f(P_IDLE, 4'd0, 16'd0, 1'b0, 1'b0);
        vectors++; if (o !== e) begin errors++; $display("FAIL rand_rest n%0d: got %h want %h", n, o, e); end
      end else pc = pc + 4'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      prog[i]  = 16'd0;
      dregs[i] = 16'd0;
    end
    test_reset();
    test_alu();
    test_move();
    test_jump();
    test_load_store();
    test_wrap();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
